trigger_sequencer: RTL and testbench
====================================

Name: trigger_sequencer

Overview:
Arms the glitch chain, drives the target reset line, waits for a qualified external trigger, and then issues the single-cycle enable that starts the pulser.
- Upstream: the UART command handler, which supplies arm/abort strobes and configuration.
- Downstream: the pulser, which receives pulse_en_o and returns its busy flag.
- Owns the trigger input synchroniser, edge qualification and wait-for-trigger timeout.

Parameters:
SYNC_STAGES, 2, number of flops in the trigger_i synchroniser (minimum 2)
RST_W, 16, width of the target reset duration counter
TMO_W, 24, width of the wait-for-trigger timeout counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
arm_i  input  1  one-cycle strobe: start a sequence
abort_i  input  1  one-cycle strobe: cancel any sequence
trigger_i  input  1  asynchronous external trigger pin
edge_sel_i  input  2  trigger mode: 00 rising, 01 falling, 10 either edge, 11 level-high
reset_cycles_i  input  RST_W  target reset assertion length in clk cycles (0 = skip reset)
timeout_i  input  TMO_W  max cycles spent in WAIT_TRIG (0 = wait forever)
pulser_busy_i  input  1  busy flag from the pulser
pulse_en_o  output  1  one-cycle start strobe to the pulser
target_reset_o  output  1  target reset drive, active-high
armed_o  output  1  high while in WAIT_TRIG
timeout_o  output  1  sticky: last sequence ended by timeout
busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; synchroniser, edge-history, counters and all outputs reset to 0.
- Config capture: edge_sel_i, reset_cycles_i and timeout_i are registered when arm_i is accepted in IDLE. Later input changes do not affect the running sequence.
- States and transitions:
  - IDLE: on arm_i, capture config and clear timeout_o. Go to RESET if reset_cycles≠0, else WAIT_TRIG. arm_i in any other state is ignored.
  - RESET: target_reset_o=1 for exactly reset_cycles consecutive cycles, then go to WAIT_TRIG.
  - WAIT_TRIG:
    - armed_o=1.
    - On entry, the edge-history register is loaded with the current synchroniser output, so a level already present is not taken as an edge.
    - Detection per mode, comparing sync output S with history H:
      - rising: S & ~H
      - falling: ~S & H
      - either: S ^ H
      - level-high: S
    - On detection, go to FIRE.
    - If timeout≠0, a cycle counter starts at 0 on entry; when it reaches timeout-1 with no detection, set timeout_o and go to IDLE.
  - FIRE: pulse_en_o=1 for this single cycle, then go to WAIT_DONE.
  - WAIT_DONE: stay for at least 2 cycles (absorbs pulser start latency), then return to IDLE on the first cycle with pulser_busy_i=0.
- Trigger latency: if clk edge k is the first to sample the new trigger_i level, pulse_en_o is high during the cycle after edge k+SYNC_STAGES.
- All outputs are registered or pure state decodes; no combinational path from any input to any output.
- Simultaneous events:
  - abort_i beats everything: from any state, go to IDLE next cycle and drop target_reset_o/armed_o. timeout_o is unchanged.
  - abort_i and arm_i in the same cycle in IDLE: stay IDLE.
  - Detection and timeout expiry in the same cycle: detection wins, timeout_o is not set.
- Counters saturate and never wrap. The maximum reset length is 2^RST_W-1 cycles.
- pulser_busy_i is ignored outside WAIT_DONE.

Test Plan:
- Reset and basic rising sequence: rst low then high; arm with reset_cycles=5, edge_sel=00, timeout=0; raise trigger_i 20 cycles later -> target_reset_o high exactly 5 cycles; armed_o high until detection; one pulse_en_o cycle 2 cycles after the sampling edge; busy_o low once pulser_busy_i falls.
- Pre-existing level: trigger_i held high before arm, rising mode -> no fire. Drop then raise trigger_i -> fires once. Repeat in level-high mode -> fires at WAIT_TRIG entry +1.
- Falling and either-edge modes: pulse trigger_i 0→1→0 -> falling fires once on the 1→0 transition; either-edge fires on the first transition only.
- Timeout: timeout=100, no trigger -> armed_o high exactly 100 cycles, then IDLE with timeout_o=1. The next arm clears timeout_o.
- Abort mid-RESET with reset_cycles=1000 at cycle 10 -> target_reset_o low next cycle, state IDLE, no pulse_en_o. arm_i during WAIT_TRIG is ignored, with no config change.
- Races: trigger detection on the same cycle as timeout expiry -> pulse_en_o fires and timeout_o=0. Async rst low in WAIT_DONE -> all outputs 0 immediately.

Source files
------------

// File: rtl/trigger_sequencer.sv
// Trigger sequencer: arms the glitch chain, holds the target in reset, waits for a
// qualified external trigger and issues a single-cycle start strobe to the pulser.
module trigger_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_W       = 16,
  parameter int TMO_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             trigger_i,
  input  logic [1:0]       edge_sel_i,
  input  logic [RST_W-1:0] reset_cycles_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             pulser_busy_i,
  output logic             pulse_en_o,
  output logic             target_reset_o,
  output logic             armed_o,
  output logic             timeout_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT_TRIG,
    S_FIRE,
    S_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    EDGE_RISE  = 2'b00,
    EDGE_FALL  = 2'b01,
    EDGE_ANY   = 2'b10,
    LEVEL_HIGH = 2'b11
  } edge_mode_t;

  state_t           state;
  edge_mode_t       mode_q;
  logic [RST_W-1:0] rst_len_q;
  logic [TMO_W-1:0] tmo_q;
  logic [RST_W-1:0] rst_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_seen;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_s;
  logic                   hist_q;
  logic                   hit;
  logic                   rst_last;
  logic                   tmo_last;

  // Metastability guard for the asynchronous trigger pin; only the last stage is used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values of its neighbours, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
    end
  end

  assign trig_s = sync_q[SYNC_STAGES-1];

  // History tracks the previous synchronised level in every state, so on WAIT_TRIG
  // entry it already holds the current level and a static level never reads as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= trig_s;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves hit unassigned,
    // which would otherwise infer a latch.
    hit = 1'b0;
    case (mode_q)
      EDGE_RISE:  hit = trig_s & ~hist_q;
      EDGE_FALL:  hit = ~trig_s & hist_q;
      EDGE_ANY:   hit = trig_s ^ hist_q;
      LEVEL_HIGH: hit = trig_s;
      default:    hit = 1'b0;
    endcase
  end

  assign rst_last = (rst_cnt == rst_len_q - RST_W'(1));
  assign tmo_last = (tmo_q != '0) && (tmo_cnt == tmo_q - TMO_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      mode_q         <= EDGE_RISE;
      rst_len_q      <= '0;
      tmo_q          <= '0;
      rst_cnt        <= '0;
      tmo_cnt        <= '0;
      done_seen      <= 1'b0;
      pulse_en_o     <= 1'b0;
      target_reset_o <= 1'b0;
      armed_o        <= 1'b0;
      timeout_o      <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      pulse_en_o <= 1'b0;
      if (abort_i) begin
        // Abort outranks arm, detection and expiry; timeout_o keeps its last value.
        state          <= S_IDLE;
        target_reset_o <= 1'b0;
        armed_o        <= 1'b0;
        busy_o         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_i) begin
              mode_q    <= edge_mode_t'(edge_sel_i);
              rst_len_q <= reset_cycles_i;
              tmo_q     <= timeout_i;
              rst_cnt   <= '0;
              tmo_cnt   <= '0;
              timeout_o <= 1'b0;
              busy_o    <= 1'b1;
              if (reset_cycles_i != '0) begin
                state          <= S_RESET;
                target_reset_o <= 1'b1;
              end else begin
                state   <= S_WAIT_TRIG;
                armed_o <= 1'b1;
              end
            end
          end

          S_RESET: begin
            if (rst_last) begin
              state          <= S_WAIT_TRIG;
              target_reset_o <= 1'b0;
              armed_o        <= 1'b1;
            end else if (rst_cnt != '1) begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end

          S_WAIT_TRIG: begin
            // Detection is tested first so it wins over a coincident expiry.
            if (hit) begin
              state      <= S_FIRE;
              armed_o    <= 1'b0;
              pulse_en_o <= 1'b1;
            end else if (tmo_last) begin
              state     <= S_IDLE;
              armed_o   <= 1'b0;
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
            end else if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          S_FIRE: begin
            state     <= S_WAIT_DONE;
            done_seen <= 1'b0;
          end

          S_WAIT_DONE: begin
            // The first cycle is unconditional so the pulser has time to raise busy.
            if (!done_seen) begin
              done_seen <= 1'b1;
            end else if (!pulser_busy_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end

          default: begin
            state          <= S_IDLE;
            target_reset_o <= 1'b0;
            armed_o        <= 1'b0;
            busy_o         <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sequence-level invariants.
  a_pulse_single: assert property (@(posedge clk) disable iff (!rst) pulse_en_o |=> !pulse_en_o);
  a_arm_excl:     assert property (@(posedge clk) disable iff (!rst) !(armed_o && target_reset_o));

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: directed stimulus queues expected events,
// a negedge monitor turns DUT output activity into events and compares them in order.
module tb_trigger_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int RST_W       = 16;
  localparam int TMO_W       = 24;

  logic             clk;
  logic             rst;
  logic             arm_i;
  logic             abort_i;
  logic             trigger_i;
  logic [1:0]       edge_sel_i;
  logic [RST_W-1:0] reset_cycles_i;
  logic [TMO_W-1:0] timeout_i;
  logic             pulser_busy_i;
  logic             pulse_en_o;
  logic             target_reset_o;
  logic             armed_o;
  logic             timeout_o;
  logic             busy_o;

  trigger_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_W      (RST_W),
    .TMO_W      (TMO_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .trigger_i     (trigger_i),
    .edge_sel_i    (edge_sel_i),
    .reset_cycles_i(reset_cycles_i),
    .timeout_i     (timeout_i),
    .pulser_busy_i (pulser_busy_i),
    .pulse_en_o    (pulse_en_o),
    .target_reset_o(target_reset_o),
    .armed_o       (armed_o),
    .timeout_o     (timeout_o),
    .busy_o        (busy_o)
  );

  typedef enum int {EV_RST_LEN, EV_ARM_LEN, EV_TMO, EV_PULSE, EV_BUSY_FALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected %s: got value %0d, expected no event (cycle %0d)", k.name(), v, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event kind", int'(k), int'(e.kind));
      check(e.kind.name(), v, e.val);
    end
  endtask

  // Monitor: run lengths are reported when a run ends, strobes with their cycle number.
  int   rst_run  = 0;
  int   arm_run  = 0;
  logic prev_tmo = 1'b0;
  logic prev_bsy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      rst_run  = 0;
      arm_run  = 0;
      prev_tmo = 1'b0;
      prev_bsy = 1'b0;
    end else begin
      if (target_reset_o) rst_run++;
      else if (rst_run > 0) begin got(EV_RST_LEN, rst_run); rst_run = 0; end
      if (armed_o) arm_run++;
      else if (arm_run > 0) begin got(EV_ARM_LEN, arm_run); arm_run = 0; end
      if (timeout_o && !prev_tmo) got(EV_TMO, cyc);
      if (pulse_en_o) got(EV_PULSE, cyc);
      if (!busy_o && prev_bsy) got(EV_BUSY_FALL, cyc);
      prev_tmo = timeout_o;
      prev_bsy = busy_o;
    end
  end

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Arm strobe issued at cycle n (sampled by edge n+1); config is scrambled afterwards.
  task automatic arm(input logic [1:0] sel, input int rc, input int tmo, output int n);
    edge_sel_i     = sel;
    reset_cycles_i = RST_W'(rc);
    timeout_i      = TMO_W'(tmo);
    arm_i          = 1'b1;
    n              = cyc;
    step();
    arm_i          = 1'b0;
    edge_sel_i     = ~sel;
    reset_cycles_i = RST_W'(16'hBEEF);
    timeout_i      = TMO_W'(3);
  endtask

  initial begin
    int n;
    rst            = 1'b0;
    arm_i          = 1'b0;
    abort_i        = 1'b0;
    trigger_i      = 1'b0;
    edge_sel_i     = 2'b00;
    reset_cycles_i = '0;
    timeout_i      = '0;
    pulser_busy_i  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset pulse_en_o", pulse_en_o, 0);
    check("reset target_reset_o", target_reset_o, 0);
    check("reset armed_o", armed_o, 0);
    check("reset timeout_o", timeout_o, 0);
    check("reset busy_o", busy_o, 0);
    step();
    rst = 1'b1;
    step();
    step();

    // Rising edge with a 5-cycle target reset; pulser busy for 10 cycles.
    arm(2'b00, 5, 0, n);
    push(EV_RST_LEN, 5);
    push(EV_ARM_LEN, 17);
    push(EV_PULSE, n + 23);
    push(EV_BUSY_FALL, n + 34);
    wait_until(n + 10);
    @(negedge clk);
    check("busy_o mid sequence", busy_o, 1);
    wait_until(n + 20); trigger_i = 1'b1;
    wait_until(n + 23); pulser_busy_i = 1'b1;
    wait_until(n + 33); pulser_busy_i = 1'b0; trigger_i = 1'b0;
    wait_until(n + 40);

    // Pre-existing high level in rising mode: only a fresh rise fires.
    trigger_i = 1'b1;
    wait_until(cyc + 4);
    arm(2'b00, 0, 0, n);
    push(EV_ARM_LEN, 17);
    push(EV_PULSE, n + 18);
    push(EV_BUSY_FALL, n + 21);
    wait_until(n + 12); trigger_i = 1'b0;
    wait_until(n + 15); trigger_i = 1'b1;
    wait_until(n + 26);

    // Level-high mode with the level already present fires one cycle after entry.
    arm(2'b11, 0, 0, n);
    push(EV_ARM_LEN, 1);
    push(EV_PULSE, n + 2);
    push(EV_BUSY_FALL, n + 5);
    wait_until(n + 8);
    trigger_i = 1'b0;
    wait_until(cyc + 4);

    // Falling mode: the 0->1 transition is ignored, the 1->0 one fires.
    arm(2'b01, 0, 0, n);
    push(EV_ARM_LEN, 11);
    push(EV_PULSE, n + 12);
    push(EV_BUSY_FALL, n + 15);
    wait_until(n + 5); trigger_i = 1'b1;
    wait_until(n + 9); trigger_i = 1'b0;
    wait_until(n + 18);

    // Either-edge mode: fires on the first transition only.
    arm(2'b10, 0, 0, n);
    push(EV_ARM_LEN, 7);
    push(EV_PULSE, n + 8);
    push(EV_BUSY_FALL, n + 11);
    wait_until(n + 5); trigger_i = 1'b1;
    wait_until(n + 9); trigger_i = 1'b0;
    wait_until(n + 16);

    // Timeout of 100 cycles with no trigger.
    arm(2'b00, 0, 100, n);
    push(EV_ARM_LEN, 100);
    push(EV_TMO, n + 101);
    push(EV_BUSY_FALL, n + 101);
    wait_until(n + 104);
    @(negedge clk);
    check("timeout_o sticky", timeout_o, 1);

    // Arm and abort together in IDLE: nothing starts, timeout_o kept.
    step();
    edge_sel_i = 2'b11; reset_cycles_i = RST_W'(4); arm_i = 1'b1; abort_i = 1'b1;
    step();
    arm_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    check("arm+abort busy_o", busy_o, 0);
    check("arm+abort target_reset_o", target_reset_o, 0);
    check("arm+abort timeout_o", timeout_o, 1);
    wait_until(cyc + 6);

    // Next accepted arm clears timeout_o; a second arm in WAIT_TRIG changes nothing.
    arm(2'b00, 3, 0, n);
    push(EV_RST_LEN, 3);
    push(EV_ARM_LEN, 6);
    push(EV_PULSE, n + 10);
    push(EV_BUSY_FALL, n + 13);
    @(negedge clk);
    check("arm clears timeout_o", timeout_o, 0);
    wait_until(n + 6);
    edge_sel_i = 2'b01; reset_cycles_i = RST_W'(7); timeout_i = TMO_W'(2); arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    trigger_i = 1'b1;
    wait_until(n + 16);
    trigger_i = 1'b0;
    wait_until(cyc + 4);

    // Abort during a long target reset.
    arm(2'b00, 1000, 0, n);
    push(EV_RST_LEN, 10);
    push(EV_BUSY_FALL, n + 11);
    wait_until(n + 10);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    @(negedge clk);
    check("abort target_reset_o", target_reset_o, 0);
    check("abort armed_o", armed_o, 0);
    check("abort busy_o", busy_o, 0);
    wait_until(cyc + 10);

    // Detection in the same cycle as timeout expiry: detection wins.
    arm(2'b00, 0, 10, n);
    push(EV_ARM_LEN, 10);
    push(EV_PULSE, n + 11);
    wait_until(n + 8); trigger_i = 1'b1;
    wait_until(n + 11); pulser_busy_i = 1'b1;
    @(negedge clk);
    check("race timeout_o", timeout_o, 0);

    // Asynchronous reset while in WAIT_DONE clears outputs without a clock edge.
    wait_until(n + 14);
    check("busy_o before async reset", busy_o, 1);
    rst = 1'b0;
    #1;
    check("async reset busy_o", busy_o, 0);
    check("async reset pulse_en_o", pulse_en_o, 0);
    check("async reset armed_o", armed_o, 0);
    check("async reset target_reset_o", target_reset_o, 0);
    check("async reset timeout_o", timeout_o, 0);
    pulser_busy_i = 1'b0;
    trigger_i     = 1'b0;
    step();
    step();
    rst = 1'b1;
    wait_until(cyc + 6);

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
